// File: rtl/ascon_perm_core_if.sv
// rtl/ascon_perm_core_if.sv - request/response bundle for the Ascon permutation core
interface ascon_perm_core_if;
   logic         in_valid;
   logic         in_ready;
   logic [1:0]   rounds_sel;
   logic [319:0] state_in;
   logic         out_valid;
   logic         out_ready;
   logic [319:0] state_out;
   logic         busy;

   modport master (
      output in_valid, rounds_sel, state_in, out_ready,
      input  in_ready, out_valid, state_out, busy
   );

   modport slave (
      input  in_valid, rounds_sel, state_in, out_ready,
      output in_ready, out_valid, state_out, busy
   );
endinterface

// File: rtl/ascon_perm_core.sv
// rtl/ascon_perm_core.sv - iterative Ascon p12/p8/p6 permutation, UNROLL rounds per clock
module ascon_perm_core #(
   parameter int UNROLL = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   ascon_perm_core_if.slave   bus
);

   if (UNROLL < 1 || UNROLL > 4) begin : g_bad_unroll
      $error("ascon_perm_core: UNROLL must be 1, 2, 3 or 4");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fsm_t;

   fsm_t         fsm_q;
   logic [319:0] state_q;
   logic [3:0]   rnd_q;
   logic         in_ready_q;
   logic         out_valid_q;
   logic         busy_q;

   logic [319:0] state_d;
   logic [3:0]   rnd_d;
   logic [3:0]   start_rnd;

   // One full Ascon round: constant addition, bit-sliced S-box, linear diffusion.
   function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] r);
      logic [63:0] x0, x1, x2, x3, x4;
      logic [63:0] t0, t1, t2, t3, t4;
      x0 = s[319:256];
      x1 = s[255:192];
      x2 = s[191:128];
      x3 = s[127:64];
      x4 = s[63:0];
      x2[7:0] = x2[7:0] ^ {4'd15 - r, r};
      x0 = x0 ^ x4;
      x4 = x4 ^ x3;
      x2 = x2 ^ x1;
      t0 = ~x0 & x1;
      t1 = ~x1 & x2;
      t2 = ~x2 & x3;
      t3 = ~x3 & x4;
      t4 = ~x4 & x0;
      x0 = x0 ^ t1;
      x1 = x1 ^ t2;
      x2 = x2 ^ t3;
      x3 = x3 ^ t4;
      x4 = x4 ^ t0;
      x1 = x1 ^ x0;
      x0 = x0 ^ x4;
      x3 = x3 ^ x2;
      x2 = ~x2;
      x0 = x0 ^ {x0[18:0], x0[63:19]} ^ {x0[27:0], x0[63:28]};
      x1 = x1 ^ {x1[60:0], x1[63:61]} ^ {x1[38:0], x1[63:39]};
      x2 = x2 ^ {x2[0],    x2[63:1]}  ^ {x2[5:0],  x2[63:6]};
      x3 = x3 ^ {x3[9:0],  x3[63:10]} ^ {x3[16:0], x3[63:17]};
      x4 = x4 ^ {x4[6:0],  x4[63:7]}  ^ {x4[40:0], x4[63:41]};
      return {x0, x1, x2, x3, x4};
   endfunction

   // Chain of UNROLL rounds; slots past round 11 leave the state untouched.
   logic [319:0] stage [UNROLL+1];
   assign stage[0] = state_q;

   for (genvar i = 0; i < UNROLL; i++) begin : g_round
      logic [3:0] r_idx;
      assign r_idx      = rnd_q + 4'(i);
      assign stage[i+1] = (r_idx < 4'd12) ? ascon_round(stage[i], r_idx) : stage[i];
   end

   // Next datapath values: saturate the round counter at 12 on the last cycle.
   always_comb begin
      state_d = stage[UNROLL];
      rnd_d   = (rnd_q >= 4'(12 - UNROLL)) ? 4'd12 : rnd_q + 4'(UNROLL);
      case (bus.rounds_sel)
         2'd1:    start_rnd = 4'd4;
         2'd2:    start_rnd = 4'd6;
         default: start_rnd = 4'd0;
      endcase
   end

   // Control FSM with registered handshake outputs; owns the state register and round counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fsm_q       <= IDLE;
         state_q     <= '0;
         rnd_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (fsm_q)
            IDLE: begin
               if (bus.in_valid) begin
                  state_q    <= bus.state_in;
                  rnd_q      <= start_rnd;
                  fsm_q      <= RUN;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            RUN: begin
               state_q <= state_d;
               rnd_q   <= rnd_d;
               if (rnd_d == 4'd12) begin
                  fsm_q       <= DONE;
                  busy_q      <= 1'b0;
                  out_valid_q <= 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  fsm_q       <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               fsm_q       <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.state_out = state_q;
   assign bus.busy      = busy_q;

endmodule
